// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, imem address, IF/ID register with stall, redirect/flush and end-of-image halt.
// Optional FETCH_MISALIGN_CHECK_EN adds a FAULT state for misaligned redirect targets.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int          IMEM_BYTES = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    output logic [63:0] ifid_pc,
    output logic [31:0] ifid_instruction,
    output logic        ifid_valid,
    output logic        halted,
    output logic        misalign_fault,
    output logic [31:0] fetch_count
);
`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;
`else
    typedef enum logic [1:0] {RUN, HALT} state_t;
`endif

    state_t      state, state_n;
    logic [63:0] pc, pc_n, ifid_pc_n;
    logic [31:0] ifid_instruction_n, fetch_count_n;
    logic        ifid_valid_n;
    logic        fits;

    // 65-bit compare so a PC near 2^64 cannot wrap into the legal range
    assign fits         = ({1'b0, pc} + 65'd4) <= 65'(IMEM_BYTES);
    assign Inst_Address = pc;
    assign halted       = state == HALT;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            misalign_fault <= 1'b0;
        else
            misalign_fault <= fault_n;
    end
`else
    assign misalign_fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= RUN;
            pc               <= RESET_PC;
            ifid_pc          <= 64'd0;
            ifid_instruction <= 32'd0;
            ifid_valid       <= 1'b0;
            fetch_count      <= 32'd0;
        end else begin
            state            <= state_n;
            pc               <= pc_n;
            ifid_pc          <= ifid_pc_n;
            ifid_instruction <= ifid_instruction_n;
            ifid_valid       <= ifid_valid_n;
            fetch_count      <= fetch_count_n;
        end
    end

    always_comb begin
        state_n            = state;
        pc_n               = pc;
        ifid_pc_n          = ifid_pc;
        ifid_instruction_n = ifid_instruction;
        ifid_valid_n       = ifid_valid;
        fetch_count_n      = fetch_count;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_n            = misalign_fault;
`endif
        if (branch_taken) begin
            ifid_valid_n       = 1'b0;
            ifid_pc_n          = 64'd0;
            ifid_instruction_n = 32'd0;
`ifdef FETCH_MISALIGN_CHECK_EN
            pc_n    = branch_target;
            state_n = |branch_target[1:0] ? FAULT : RUN;
            fault_n = |branch_target[1:0];
`else
            pc_n    = {branch_target[63:2], 2'b00};
            state_n = RUN;
`endif
        end else if (state == RUN && !stall) begin
            if (fits) begin
                ifid_pc_n          = pc;
                ifid_instruction_n = Instruction;
                ifid_valid_n       = 1'b1;
                pc_n               = pc + 64'd4;
                fetch_count_n      = fetch_count + 32'd1;
            end else begin
                ifid_valid_n = 1'b0;
                state_n      = HALT;
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed stimulus, per-cycle model comparison plus literal spot checks.
module tb_instruction_fetch_unit;
    localparam int IMEM_BYTES = 20;

    logic        clk = 0, reset = 1, stall = 0, branch_taken = 0;
    logic [63:0] branch_target = 0, Inst_Address, ifid_pc;
    logic [31:0] Instruction, ifid_instruction, fetch_count;
    logic        ifid_valid, halted, misalign_fault;
    int          checks = 0, failures = 0;

    logic [31:0] mem [0:4] = '{32'h02853483, 32'h009A84B3, 32'h00148493, 32'h00000013, 32'hFFDFF06F};

    always #5 clk = ~clk;

    assign Instruction = (Inst_Address < 64'(IMEM_BYTES)) ? mem[Inst_Address[4:2]] : 32'h0;

    instruction_fetch_unit #(.RESET_PC(64'd0), .IMEM_BYTES(IMEM_BYTES)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .Inst_Address(Inst_Address), .Instruction(Instruction),
        .ifid_pc(ifid_pc), .ifid_instruction(ifid_instruction), .ifid_valid(ifid_valid),
        .halted(halted), .misalign_fault(misalign_fault), .fetch_count(fetch_count)
    );

    // Reference: what the fetch stage must hold after each edge
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_inst, m_cnt;
    logic        m_valid, m_halt, m_fault, m_stopped;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 0; m_ipc = 0; m_inst = 0; m_cnt = 0;
            m_valid = 0; m_halt = 0; m_fault = 0; m_stopped = 0;
        end else if (branch_taken) begin
            m_valid = 0; m_ipc = 0; m_inst = 0; m_halt = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
            m_pc = branch_target;
            m_fault = branch_target % 4 != 0;
            m_stopped = m_fault;
`else
            m_pc = branch_target - (branch_target % 4);
            m_stopped = 0;
`endif
        end else if (!m_stopped && !stall) begin
            if (m_pc <= 64'(IMEM_BYTES - 4)) begin
                m_ipc = m_pc;
                m_inst = mem[m_pc / 4];
                m_valid = 1;
                m_pc = m_pc + 4;
                m_cnt = m_cnt + 1;
            end else begin
                m_valid = 0; m_halt = 1; m_stopped = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_addr", Inst_Address, m_pc);
        chk("m_ifid_pc", ifid_pc, m_ipc);
        chk("m_ifid_inst", 64'(ifid_instruction), 64'(m_inst));
        chk("m_valid", 64'(ifid_valid), 64'(m_valid));
        chk("m_halted", 64'(halted), 64'(m_halt));
        chk("m_fault", 64'(misalign_fault), 64'(m_fault));
        chk("m_count", 64'(fetch_count), 64'(m_cnt));
    end

    task automatic go(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #3;
        chk("rst_addr", Inst_Address, 0);
        chk("rst_valid", 64'(ifid_valid), 0);
        chk("rst_count", 64'(fetch_count), 0);
        chk("rst_halted", 64'(halted), 0);
        @(posedge clk); #2; reset = 0;
        go();
        chk("e1_pc", ifid_pc, 0);
        chk("e1_inst", 64'(ifid_instruction), 64'h02853483);
        chk("e1_valid", 64'(ifid_valid), 1);
        go();
        chk("e2_pc", ifid_pc, 4);
        chk("e2_inst", 64'(ifid_instruction), 64'h009A84B3);
        stall = 1;
        go(3);
        chk("stall_pc", ifid_pc, 4);
        chk("stall_addr", Inst_Address, 8);
        chk("stall_count", 64'(fetch_count), 2);
        stall = 0;
        go();
        chk("resume_pc", ifid_pc, 8);
        go(3);
        chk("halt_valid", 64'(ifid_valid), 0);
        chk("halt_halted", 64'(halted), 1);
        chk("halt_addr", Inst_Address, 20);
        chk("halt_count", 64'(fetch_count), 5);
        stall = 1;
        go(2);
        chk("halt_stall", 64'(halted), 1);
        stall = 0;
        go();
        branch_taken = 1; branch_target = 0;
        go();
        branch_taken = 0;
        chk("redir0_halted", 64'(halted), 0);
        chk("redir0_valid", 64'(ifid_valid), 0);
        go();
        chk("redir0_pc", ifid_pc, 0);
        chk("redir0_v", 64'(ifid_valid), 1);
        go();
        stall = 1; branch_taken = 1; branch_target = 8;
        go();
        branch_taken = 0; stall = 0;
        chk("bs_valid", 64'(ifid_valid), 0);
        chk("bs_addr", Inst_Address, 8);
        go();
        chk("bs_pc", ifid_pc, 8);
        chk("bs_inst", 64'(ifid_instruction), 64'h00148493);
        branch_taken = 1; branch_target = 6;
        go();
        branch_taken = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_fault", 64'(misalign_fault), 1);
        go(2);
        chk("mis_valid", 64'(ifid_valid), 0);
        branch_taken = 1; branch_target = 4;
        go();
        branch_taken = 0;
        chk("mis_clear", 64'(misalign_fault), 0);
        go();
        chk("mis_resume", ifid_pc, 4);
`else
        chk("mis_addr", Inst_Address, 4);
        chk("mis_fault", 64'(misalign_fault), 0);
        go();
        chk("mis_pc", ifid_pc, 4);
        chk("mis_inst", 64'(ifid_instruction), 64'h009A84B3);
`endif
        go();
        #1 reset = 1;
        #1;
        chk("async_addr", Inst_Address, 0);
        chk("async_valid", 64'(ifid_valid), 0);
        chk("async_count", 64'(fetch_count), 0);
        chk("async_ipc", ifid_pc, 0);
        go();
        reset = 0;
        go(3);
        chk("post_pc", ifid_pc, 8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end fetch stage of the 5-stage RISC-V pipeline. Holds the 64-bit program counter, drives the combinational byte-addressed instruction memory, and captures the returned 32-bit instruction together with its PC into the IF/ID pipeline register. Supports decode-stage stall, execute-stage branch redirect with flush, and halts cleanly when the PC runs past the end of the instruction image.

## Interface
- `RESET_PC`, 64'd0, PC value loaded on reset
- `IMEM_BYTES`, 20, size of the instruction memory in bytes; the last legal fetch address is IMEM_BYTES-4
- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-high; clears all state
- `stall` input 1: hazard unit request to hold PC and IF/ID
- `branch_taken` input 1: redirect request from EX
- `branch_target` input 64: redirect address
- `Inst_Address` output 64: to instruction memory, equals current PC (combinational)
- `Instruction` input 32: from instruction memory, little-endian word at Inst_Address
- `ifid_pc` output 64: PC of captured instruction
- `ifid_instruction` output 32: captured instruction
- `ifid_valid` output 1: IF/ID holds a real instruction (0 = bubble)
- `halted` output 1: unit is in HALT
- `misalign_fault` output 1: sticky misaligned-redirect flag
- `fetch_count` output 32: number of instructions captured with valid=1

## Operation
- States: RUN, HALT, FAULT (FAULT only exists with the macro enabled).
- Per-edge priority: reset > branch_taken > stall > normal advance.
- branch_taken (any state, stall ignored): pc <= branch_target; ifid_valid <= 0; ifid_pc/ifid_instruction <= 0; state <= RUN (or FAULT, see Configuration). fetch_count unchanged.
- stall (RUN, no redirect): pc, IF/ID, state, fetch_count all hold.
- RUN advance, pc+4 <= IMEM_BYTES (compared in 65 bits, no overflow): ifid_pc <= pc; ifid_instruction <= Instruction; ifid_valid <= 1; pc <= pc+4; fetch_count <= fetch_count+1 (wraps at 2^32).
- RUN advance, pc+4 > IMEM_BYTES: ifid_valid <= 0; pc holds; state <= HALT.
- HALT: pc holds, ifid_valid stays 0, stall has no effect; exit only via branch_taken or reset.
- halted = (state == HALT).

## Timing
- Reset values: pc = RESET_PC, ifid_pc = 0, ifid_instruction = 0, ifid_valid = 0, halted = 0, misalign_fault = 0, fetch_count = 0, state = RUN.
- Inst_Address changes only on clk edges or reset; memory read is combinational within the same cycle.
- Fetch latency: the instruction at PC X appears on ifid_* one edge after pc becomes X.
- Redirect penalty: one bubble; target instruction appears on ifid_* two edges after branch_taken is sampled.
- Reset asserted mid-stream: all outputs return to reset values immediately, without waiting for clk.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: a redirect with branch_target[1:0] != 0 loads pc <= branch_target, ifid_valid <= 0, state <= FAULT, misalign_fault <= 1. FAULT behaves like HALT (no fetch, stall ignored). misalign_fault stays 1 until reset or until an aligned redirect returns the unit to RUN.
- Not defined: branch_target[1:0] is forced to 2'b00 on redirect; FAULT state is not built; misalign_fault is tied to 0.

## Test plan
- Reset then release, default image: edge 1 gives ifid_pc=0, ifid_instruction=0x02853483, valid=1; edge 2 gives ifid_pc=4, ifid_instruction=0x009A84B3.
- Free-run from 0 with IMEM_BYTES=20: five valid fetches (PCs 0..16), then ifid_valid=0, halted=1, pc stays 20, fetch_count=5.
- While ifid_pc=4, hold stall high for 3 cycles: pc, ifid_*, and fetch_count unchanged; fetching resumes with PC 8 on release.
- branch_taken=1, target=8, with stall also high: next edge gives ifid_valid=0, pc=8; following edge gives ifid_pc=8, ifid_instruction=0x00148493.
- Redirect to target=0 while halted: halted drops; two edges later ifid_pc=0 with valid=1.
- With FETCH_MISALIGN_CHECK_EN, redirect to 6: misalign_fault=1, ifid_valid stays 0; a redirect to 4 clears the fault and fetch resumes at 4. Without the macro, a redirect to 6 fetches at 4.
